seg7_anim_sequencer: RTL and testbench

Parametrised frame sequencer for the seven-segment animation design, the successor to the fixed single-mode animation/speed controller. It takes debounced one-shot button pulses and produces the current animation index, the current frame index and a one-cycle frame tick for the segment decoder. Period bounds and widths are parametrised. It adds four playback modes (forward, reverse, ping-pong, one-shot), pause, exact-period ticking and saturating speed arithmetic. It sits between the button debouncers and the seg7 decoder / frame-limit lookup.

---
 rtl/seg7_anim_sequencer.sv | 179 +++++++++++++++++
 tb/tb_seg7_anim_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_anim_sequencer.sv
// Frame sequencer for the seven-segment animation: it tracks the animation index,
// the frame index, the playback mode and the speed, and emits one frame tick per period.
module seg7_anim_sequencer #(
    parameter int CNT_W       = 25,
    parameter int PERIOD_RST  = 10_000_000,
    parameter int PERIOD_MIN  = 1_000_000,
    parameter int PERIOD_MAX  = 20_000_000,
    parameter int PERIOD_STEP = 1_000_000,
    parameter int ANI_W       = 6,
    parameter int ANI_MAX     = 50,
    parameter int FRM_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ani_inc,
    input  logic             ani_dec,
    input  logic             period_up,
    input  logic             period_down,
    input  logic             mode_next,
    input  logic             pause_tgl,
    input  logic [FRM_W-1:0] frame_limit,
    output logic [ANI_W-1:0] animation,
    output logic [FRM_W-1:0] frame,
    output logic [1:0]       mode,
    output logic             paused,
    output logic             done,
    output logic             frame_tick,
    output logic [CNT_W-1:0] period
);

    typedef enum logic [1:0] {
        MODE_FWD  = 2'd0,
        MODE_REV  = 2'd1,
        MODE_PING = 2'd2,
        MODE_ONCE = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] P_RST   = CNT_W'(PERIOD_RST);
    localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] P_STEP  = CNT_W'(PERIOD_STEP);
    // Bounds pre-offset by one step so the comparisons never overflow CNT_W.
    localparam logic [CNT_W-1:0] P_UP_OK = CNT_W'(PERIOD_MAX - PERIOD_STEP);
    localparam logic [CNT_W-1:0] P_DN_OK = CNT_W'(PERIOD_MIN + PERIOD_STEP);
    localparam logic [ANI_W-1:0] A_MAX   = ANI_W'(ANI_MAX);

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [ANI_W-1:0] animation_q, animation_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    mode_t            mode_q, mode_d;
    logic             paused_q, paused_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;
    logic             dir_up_q, dir_up_d;

    logic ani_change;
    logic restart;
    logic tick_due;

    assign ani_change = ani_inc ^ ani_dec;
    assign restart    = ani_change | mode_next;
    assign tick_due   = !paused_q && (counter_q >= (period_q - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q   <= '0;
            period_q    <= P_RST;
            animation_q <= '0;
            frame_q     <= '0;
            mode_q      <= MODE_FWD;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
            dir_up_q    <= 1'b1;
        end else begin
            counter_q   <= counter_d;
            period_q    <= period_d;
            animation_q <= animation_d;
            frame_q     <= frame_d;
            mode_q      <= mode_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
            tick_q      <= tick_d;
            dir_up_q    <= dir_up_d;
        end
    end

    always_comb begin
        counter_d   = counter_q;
        period_d    = period_q;
        animation_d = animation_q;
        frame_d     = frame_q;
        mode_d      = mode_q;
        paused_d    = paused_q ^ pause_tgl;
        done_d      = done_q;
        tick_d      = 1'b0;
        dir_up_d    = dir_up_q;

        if (ani_inc && !ani_dec) begin
            animation_d = (animation_q == A_MAX) ? '0 : animation_q + ANI_W'(1);
        end else if (ani_dec && !ani_inc) begin
            animation_d = (animation_q == '0) ? A_MAX : animation_q - ANI_W'(1);
        end

        if (mode_next) begin
            unique case (mode_q)
                MODE_FWD:  mode_d = MODE_REV;
                MODE_REV:  mode_d = MODE_PING;
                MODE_PING: mode_d = MODE_ONCE;
                MODE_ONCE: mode_d = MODE_FWD;
            endcase
        end

        if (period_up && !period_down) begin
            period_d = (period_q <= P_UP_OK) ? period_q + P_STEP : P_MAX;
        end else if (period_down && !period_up) begin
            period_d = (period_q >= P_DN_OK) ? period_q - P_STEP : P_MIN;
        end

        // A restart wins over a tick that falls due in the same cycle.
        if (restart) begin
            frame_d   = '0;
            counter_d = '0;
            dir_up_d  = 1'b1;
            done_d    = 1'b0;
        end else if (tick_due) begin
            counter_d = '0;
            tick_d    = 1'b1;
            unique case (mode_q)
                MODE_FWD: begin
                    frame_d = (frame_q >= frame_limit) ? '0 : frame_q + FRM_W'(1);
                end
                MODE_REV: begin
                    frame_d = (frame_q == '0 || frame_q > frame_limit) ? frame_limit
                                                                       : frame_q - FRM_W'(1);
                end
                MODE_PING: begin
                    if (dir_up_q) begin
                        if (frame_q >= frame_limit) begin
                            dir_up_d = 1'b0;
                            frame_d  = (frame_limit == '0) ? '0 : frame_limit - FRM_W'(1);
                        end else begin
                            frame_d = frame_q + FRM_W'(1);
                        end
                    end else begin
                        if (frame_q == '0) begin
                            dir_up_d = 1'b1;
                            frame_d  = (frame_limit == '0) ? '0 : FRM_W'(1);
                        end else begin
                            frame_d = frame_q - FRM_W'(1);
                        end
                    end
                end
                MODE_ONCE: begin
                    // done rises together with the step that lands on the last frame.
                    if (frame_q >= frame_limit) begin
                        frame_d = frame_limit;
                        done_d  = 1'b1;
                    end else begin
                        frame_d = frame_q + FRM_W'(1);
                        done_d  = ((frame_q + FRM_W'(1)) >= frame_limit);
                    end
                end
            endcase
        end else if (!paused_q) begin
            counter_d = counter_q + CNT_W'(1);
        end
    end

    assign animation  = animation_q;
    assign frame      = frame_q;
    assign mode       = mode_q;
    assign paused     = paused_q;
    assign done       = done_q;
    assign frame_tick = tick_q;
    assign period     = period_q;

endmodule

// File: tb/tb_seg7_anim_sequencer.sv
// Bench for seg7_anim_sequencer: directed button sequences with literal expectations,
// plus a cycle-level model that derives frames from the step count since the last restart.
module tb_seg7_anim_sequencer;

    localparam int CNT_W   = 8;
    localparam int P_RST   = 10;
    localparam int P_MIN   = 2;
    localparam int P_MAX   = 20;
    localparam int P_STEP  = 4;
    localparam int ANI_W   = 6;
    localparam int ANI_MAX = 5;
    localparam int FRM_W   = 6;
    localparam int LIM     = 3;

    localparam logic [5:0] B_AINC  = 6'b100000;
    localparam logic [5:0] B_ADEC  = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_MODE  = 6'b000010;
    localparam logic [5:0] B_PAUSE = 6'b000001;

    logic             clk = 1'b0;
    logic             reset;
    logic             ani_inc, ani_dec, period_up, period_down, mode_next, pause_tgl;
    logic [FRM_W-1:0] frame_limit;
    logic [ANI_W-1:0] animation;
    logic [FRM_W-1:0] frame;
    logic [1:0]       mode;
    logic             paused, done, frame_tick;
    logic [CNT_W-1:0] period;

    int total = 0;
    int bad   = 0;

    // Model state: frame and done are derived from the tick count k since the last restart.
    bit m_valid = 1'b0;
    int m_ani, m_mode, m_k, m_cnt, m_period;
    bit m_paused, m_tick;

    seg7_anim_sequencer #(
        .CNT_W(CNT_W), .PERIOD_RST(P_RST), .PERIOD_MIN(P_MIN), .PERIOD_MAX(P_MAX),
        .PERIOD_STEP(P_STEP), .ANI_W(ANI_W), .ANI_MAX(ANI_MAX), .FRM_W(FRM_W)
    ) dut (
        .clk(clk), .reset(reset), .ani_inc(ani_inc), .ani_dec(ani_dec),
        .period_up(period_up), .period_down(period_down), .mode_next(mode_next),
        .pause_tgl(pause_tgl), .frame_limit(frame_limit), .animation(animation),
        .frame(frame), .mode(mode), .paused(paused), .done(done),
        .frame_tick(frame_tick), .period(period)
    );

    always #5 clk = ~clk;

    function automatic int model_frame(input int md, input int k);
        int p;
        p = k % (2 * LIM);
        case (md)
            0:       return k % (LIM + 1);
            1:       return (LIM + 1 - (k % (LIM + 1))) % (LIM + 1);
            2:       return (p <= LIM) ? p : 2 * LIM - p;
            default: return (k >= LIM) ? LIM : k;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [5:0] bits);
        {ani_inc, ani_dec, period_up, period_down, mode_next, pause_tgl} = bits;
        @(negedge clk);
        {ani_inc, ani_dec, period_up, period_down, mode_next, pause_tgl} = '0;
    endtask

    task automatic wait_tick(input string name, input int gap, input int exp_frame);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        check_output({name, "_gap"}, n, gap);
        check_output({name, "_frame"}, frame, exp_frame);
    endtask

    always @(posedge clk) begin : model_update
        int  n_ani, n_mode, n_k, n_cnt, n_period;
        bit  n_paused, n_tick, due, restart;
        if (reset) begin
            n_ani = 0; n_mode = 0; n_k = 0; n_cnt = 0; n_period = P_RST;
            n_paused = 1'b0; n_tick = 1'b0;
        end else begin
            n_ani = m_ani; n_mode = m_mode; n_k = m_k; n_cnt = m_cnt; n_period = m_period;
            due     = !m_paused && (m_cnt >= m_period - 1);
            restart = (ani_inc != ani_dec) || mode_next;
            if (period_up && !period_down)
                n_period = (m_period + P_STEP > P_MAX) ? P_MAX : m_period + P_STEP;
            else if (period_down && !period_up)
                n_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
            if (ani_inc && !ani_dec)      n_ani = (m_ani + 1) % (ANI_MAX + 1);
            else if (ani_dec && !ani_inc) n_ani = (m_ani + ANI_MAX) % (ANI_MAX + 1);
            if (mode_next) n_mode = (m_mode + 1) % 4;
            if (restart) begin
                n_k = 0; n_cnt = 0; n_tick = 1'b0;
            end else if (due) begin
                n_k = m_k + 1; n_cnt = 0; n_tick = 1'b1;
            end else begin
                n_tick = 1'b0;
                if (!m_paused) n_cnt = m_cnt + 1;
            end
            n_paused = m_paused ^ pause_tgl;
        end
        m_ani <= n_ani; m_mode <= n_mode; m_k <= n_k; m_cnt <= n_cnt;
        m_period <= n_period; m_paused <= n_paused; m_tick <= n_tick;
        if (reset) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check_output("model_animation", animation, m_ani);
            check_output("model_frame", frame, model_frame(m_mode, m_k));
            check_output("model_mode", mode, m_mode);
            check_output("model_paused", paused, int'(m_paused));
            check_output("model_done", done, int'(m_mode == 3 && m_k >= LIM));
            check_output("model_tick", frame_tick, int'(m_tick));
            check_output("model_period", period, m_period);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ticks;
        reset = 1'b1;
        {ani_inc, ani_dec, period_up, period_down, mode_next, pause_tgl} = '0;
        frame_limit = FRM_W'(LIM);
        repeat (3) @(negedge clk);

        check_output("rst_period", period, 10);
        check_output("rst_frame", frame, 0);
        check_output("rst_tick", frame_tick, 0);
        check_output("rst_anim", animation, 0);
        check_output("rst_mode", mode, 0);
        reset = 1'b0;

        // FWD: first tick in cycle 10, then every 10 cycles.
        wait_tick("fwd1", 10, 1);
        wait_tick("fwd2", 10, 2);
        wait_tick("fwd3", 10, 3);
        wait_tick("fwd4", 10, 0);
        wait_tick("fwd5", 10, 1);

        apply_stimulus(B_MODE);
        apply_stimulus(B_MODE);
        check_output("ping_mode", mode, 2);
        check_output("ping_frame0", frame, 0);
        wait_tick("ping1", 10, 1);
        wait_tick("ping2", 10, 2);
        wait_tick("ping3", 10, 3);
        wait_tick("ping4", 10, 2);
        wait_tick("ping5", 10, 1);
        wait_tick("ping6", 10, 0);
        wait_tick("ping7", 10, 1);

        repeat (3) apply_stimulus(B_MODE);
        check_output("rev_mode", mode, 1);
        wait_tick("rev1", 10, 3);
        wait_tick("rev2", 10, 2);
        wait_tick("rev3", 10, 1);
        wait_tick("rev4", 10, 0);
        wait_tick("rev5", 10, 3);

        repeat (2) apply_stimulus(B_MODE);
        check_output("once_mode", mode, 3);
        wait_tick("once1", 10, 1);
        check_output("once1_done", done, 0);
        wait_tick("once2", 10, 2);
        check_output("once2_done", done, 0);
        wait_tick("once3", 10, 3);
        check_output("once3_done", done, 1);
        wait_tick("once4", 10, 3);
        check_output("once4_done", done, 1);
        apply_stimulus(B_MODE);
        check_output("wrap_mode", mode, 0);
        check_output("wrap_frame", frame, 0);
        check_output("wrap_done", done, 0);

        apply_stimulus(B_UP);   check_output("up1", period, 14);
        apply_stimulus(B_UP);   check_output("up2", period, 18);
        apply_stimulus(B_UP);   check_output("up3", period, 20);
        apply_stimulus(B_UP);   check_output("up4", period, 20);
        apply_stimulus(B_DOWN); check_output("dn1", period, 16);
        apply_stimulus(B_DOWN); check_output("dn2", period, 12);
        apply_stimulus(B_DOWN); check_output("dn3", period, 8);
        apply_stimulus(B_DOWN); check_output("dn4", period, 4);
        apply_stimulus(B_DOWN); check_output("dn5", period, 2);
        apply_stimulus(B_DOWN); check_output("dn6", period, 2);
        apply_stimulus(B_UP | B_DOWN); check_output("both_min", period, 2);
        apply_stimulus(B_UP);
        apply_stimulus(B_UP);   check_output("restore", period, 10);
        apply_stimulus(B_UP | B_DOWN); check_output("both_mid", period, 10);

        apply_stimulus(B_ADEC); check_output("ani_dec_wrap", animation, 5);
        check_output("ani_dec_frame", frame, 0);
        apply_stimulus(B_AINC); check_output("ani_inc_wrap", animation, 0);

        // Counter is 0 here; nine cycles later a tick is due and collides with ani_inc.
        repeat (9) @(negedge clk);
        apply_stimulus(B_AINC);
        check_output("collide_tick", frame_tick, 0);
        check_output("collide_frame", frame, 0);
        check_output("collide_anim", animation, 1);
        wait_tick("collide_next", 10, 1);

        repeat (6) @(negedge clk);
        apply_stimulus(B_PAUSE);
        check_output("pause_on", paused, 1);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ticks++;
        end
        check_output("pause_ticks", ticks, 0);
        check_output("pause_frame", frame, 1);
        // Tick lands 4 cycles after the resume pulse, i.e. 3 after this task returns.
        apply_stimulus(B_PAUSE);
        check_output("pause_off", paused, 0);
        wait_tick("resume", 3, 2);

        apply_stimulus(B_AINC | B_ADEC);
        check_output("ani_both", animation, 1);

        repeat (2) apply_stimulus(B_MODE);
        repeat (2) apply_stimulus(B_AINC);
        repeat (2) apply_stimulus(B_UP);
        apply_stimulus(B_PAUSE);
        check_output("pre_rst_mode", mode, 2);
        check_output("pre_rst_anim", animation, 3);
        check_output("pre_rst_period", period, 18);
        check_output("pre_rst_paused", paused, 1);

        reset = 1'b1;
        {ani_inc, period_up, mode_next, pause_tgl} = 4'b1111;
        @(negedge clk);
        reset = 1'b0;
        {ani_inc, ani_dec, period_up, period_down, mode_next, pause_tgl} = '0;
        check_output("mid_rst_anim", animation, 0);
        check_output("mid_rst_frame", frame, 0);
        check_output("mid_rst_mode", mode, 0);
        check_output("mid_rst_paused", paused, 0);
        check_output("mid_rst_done", done, 0);
        check_output("mid_rst_tick", frame_tick, 0);
        check_output("mid_rst_period", period, 10);
        wait_tick("post_rst", 10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
